mcpu_core_coproc_ctl: RTL and testbench

//  Parametrised core coprocessor: privilege state, exception entry/return, cause/vaddr capture,

---
 rtl/mcpu_core_coproc_ctl.sv | 183 ++++++++++++++++++
 tb/tb_mcpu_core_coproc_ctl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_coproc_ctl.sv
// rtl/mcpu_core_coproc_ctl.sv - core coprocessor: privilege state, exception entry/return with EPC stack,
// cause/vaddr capture, scratch registers, free-running cycle counter and compare-match timer interrupt.
module mcpu_core_coproc_ctl #(
  parameter int NUM_SCRATCH  = 4,
  parameter int NUM_LANES    = 4,
  parameter int ESTACK_DEPTH = 4,
  parameter int CYCLE_W      = 32
) (
  input  logic                   clkrst_core_clk,
  input  logic                   clkrst_core_rst,
  input  logic [31:0]            d2pc_in_rs_data0,
  input  logic [4:0]             d2pc_in_rs_num0,
  input  logic [4:0]             d2pc_in_rd_num0,
  input  logic [8:0]             d2pc_in_execute_opcode0,
  input  logic                   coproc_instruction,
  input  logic [5*NUM_LANES-1:0] combined_ec,
  input  logic [3:0]             int_type,
  input  logic                   exception,
  input  logic [27:0]            d2pc_in_virtpc,
  input  logic [31:0]            mem_vaddr0,
  input  logic [31:0]            mem_vaddr1,
  output logic [31:0]            coproc_reg_result,
  output logic                   coproc_rd_we,
  output logic                   coproc_branch,
  output logic [27:0]            coproc_branchaddr,
  output logic                   user_mode,
  output logic                   paging_on,
  output logic                   interrupts_enabled,
  output logic [19:0]            pagedir_base,
  output logic                   timer_irq,
  output logic                   double_fault
);

  localparam int SW = $clog2(NUM_SCRATCH);
  localparam int DW = $clog2(ESTACK_DEPTH + 1);
  localparam logic [3:0] OP_ERET = 4'b0100;
  localparam logic [3:0] OP_MFC  = 4'b0110;
  localparam logic [3:0] OP_MTC  = 4'b0111;

  logic               ie_q, ie_d, paging_q, paging_d, df_q, df_d;
  logic               user_q, user_d, pend_q, pend_d, dfp_q, dfp_d;
  logic [31:0]        ptb_q, ptb_d, eha_q, eha_d, epc_q, epc_d;
  logic [31:0]        cmp_q, cmp_d, va0_q, va0_d, va1_q, va1_d;
  logic [8:0]         ec_q [NUM_LANES];
  logic [8:0]         ec_d [NUM_LANES];
  logic [31:0]        scr_q [NUM_SCRATCH];
  logic [31:0]        scr_d [NUM_SCRATCH];
  logic [31:0]        stk_q [ESTACK_DEPTH];
  logic [31:0]        stk_d [ESTACK_DEPTH];
  logic [DW-1:0]      depth_q, depth_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [63:0]        cyc64;
  logic [3:0]         op;
  logic [3:0]         wr_idx;
  logic               is_eret, is_mtc;
  logic               unused_opcode_lsbs;

  assign op                 = d2pc_in_execute_opcode0[8:5];
  assign unused_opcode_lsbs = ^d2pc_in_execute_opcode0[4:0];
  assign is_eret            = coproc_instruction && (op == OP_ERET);
  assign is_mtc             = coproc_instruction && (op == OP_MTC);
  assign wr_idx             = d2pc_in_rd_num0[3:0];
  assign cyc64              = 64'(cyc_q);

  assign coproc_rd_we       = coproc_instruction && (op == OP_MFC);
  assign coproc_branch      = exception || is_eret;
  assign coproc_branchaddr  = exception ? eha_q[31:4] : epc_q[31:4];
  assign user_mode          = user_q;
  assign paging_on          = paging_q;
  assign interrupts_enabled = ie_q;
  assign pagedir_base       = ptb_q[31:12];
  assign timer_irq          = pend_q && ie_q;
  assign double_fault       = dfp_q;

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      ie_q <= 1'b0; paging_q <= 1'b0; df_q <= 1'b0; user_q <= 1'b0;
      pend_q <= 1'b0; dfp_q <= 1'b0;
      ptb_q <= '0; eha_q <= '0; epc_q <= '0; cmp_q <= '0; va0_q <= '0; va1_q <= '0;
      depth_q <= '0; cyc_q <= '0;
      for (int l = 0; l < NUM_LANES; l++)    ec_q[l]  <= '0;
      for (int s = 0; s < NUM_SCRATCH; s++)  scr_q[s] <= '0;
      for (int i = 0; i < ESTACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      ie_q <= ie_d; paging_q <= paging_d; df_q <= df_d; user_q <= user_d;
      pend_q <= pend_d; dfp_q <= dfp_d;
      ptb_q <= ptb_d; eha_q <= eha_d; epc_q <= epc_d; cmp_q <= cmp_d; va0_q <= va0_d; va1_q <= va1_d;
      depth_q <= depth_d; cyc_q <= cyc_d;
      for (int l = 0; l < NUM_LANES; l++)    ec_q[l]  <= ec_d[l];
      for (int s = 0; s < NUM_SCRATCH; s++)  scr_q[s] <= scr_d[s];
      for (int i = 0; i < ESTACK_DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  // Exactly one of exception / eret / mtc acts per cycle, in that priority order.
  always_comb begin
    ie_d = ie_q; paging_d = paging_q; df_d = df_q; user_d = user_q;
    ptb_d = ptb_q; eha_d = eha_q; epc_d = epc_q; cmp_d = cmp_q; va0_d = va0_q; va1_d = va1_q;
    depth_d = depth_q;
    for (int l = 0; l < NUM_LANES; l++)    ec_d[l]  = ec_q[l];
    for (int s = 0; s < NUM_SCRATCH; s++)  scr_d[s] = scr_q[s];
    for (int i = 0; i < ESTACK_DEPTH; i++) stk_d[i] = stk_q[i];
    cyc_d  = cyc_q + CYCLE_W'(1);
    pend_d = pend_q || ((cyc_q[31:0] == cmp_q) && (cmp_q != 32'h0));
    dfp_d  = 1'b0;
    if (exception) begin
      if (depth_q < DW'(ESTACK_DEPTH)) begin
        for (int i = 0; i < ESTACK_DEPTH; i++)
          if (DW'(i) == depth_q) stk_d[i] = epc_q;
        depth_d = depth_q + DW'(1);
      end else begin
        df_d  = 1'b1;
        dfp_d = 1'b1;
      end
      epc_d  = {d2pc_in_virtpc, 2'b00, ie_q, ~user_q};
      ie_d   = 1'b0;
      user_d = 1'b0;
      for (int l = 0; l < NUM_LANES; l++)
        ec_d[l] = (l == 0) ? {int_type, combined_ec[4:0]} : {4'b0000, combined_ec[5*l +: 5]};
      va0_d = mem_vaddr0;
      va1_d = mem_vaddr1;
    end else if (is_eret) begin
      user_d = ~epc_q[0];
      ie_d   = epc_q[1];
      if (depth_q != '0) begin
        for (int i = 0; i < ESTACK_DEPTH; i++)
          if (DW'(i) == depth_q - DW'(1)) epc_d = stk_q[i];
        depth_d = depth_q - DW'(1);
      end
    end else if (is_mtc) begin
      if (d2pc_in_rd_num0[4]) begin
        scr_d[d2pc_in_rd_num0[SW-1:0]] = d2pc_in_rs_data0;
      end else begin
        case (wr_idx)
          4'd0: begin
            ie_d     = d2pc_in_rs_data0[0];
            paging_d = d2pc_in_rs_data0[1];
            df_d     = df_q && d2pc_in_rs_data0[2];
          end
          4'd1: ptb_d = d2pc_in_rs_data0;
          4'd2: eha_d = d2pc_in_rs_data0;
          4'd3: epc_d = d2pc_in_rs_data0;
          4'd8: va0_d = d2pc_in_rs_data0;
          4'd9: va1_d = d2pc_in_rs_data0;
          4'd11: begin
            cmp_d  = d2pc_in_rs_data0;
            pend_d = 1'b0;
          end
          default: begin
            for (int l = 0; l < NUM_LANES; l++)
              if (int'(wr_idx) == 4 + l)
                ec_d[l] = (l == 0) ? d2pc_in_rs_data0[8:0] : {4'b0000, d2pc_in_rs_data0[4:0]};
          end
        endcase
      end
    end
  end

  always_comb begin
    coproc_reg_result = 32'h0;
    if (d2pc_in_rs_num0[4]) begin
      coproc_reg_result = scr_q[d2pc_in_rs_num0[SW-1:0]];
    end else begin
      case (d2pc_in_rs_num0[3:0])
        4'd0:  coproc_reg_result = {29'b0, df_q, paging_q, ie_q};
        4'd1:  coproc_reg_result = ptb_q;
        4'd2:  coproc_reg_result = eha_q;
        4'd3:  coproc_reg_result = epc_q;
        4'd8:  coproc_reg_result = va0_q;
        4'd9:  coproc_reg_result = va1_q;
        4'd10: coproc_reg_result = cyc64[31:0];
        4'd11: coproc_reg_result = cmp_q;
        4'd12: coproc_reg_result = cyc64[63:32];
        4'd13: coproc_reg_result = 32'(depth_q);
        default: begin
          for (int l = 0; l < NUM_LANES; l++)
            if (int'(d2pc_in_rs_num0[3:0]) == 4 + l) coproc_reg_result = {23'b0, ec_q[l]};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_core_coproc_ctl.sv
// tb/tb_mcpu_core_coproc_ctl.sv - randomized self-checking bench for mcpu_core_coproc_ctl
// against a queue-based behavioural model of the coprocessor register file.
module tb_mcpu_core_coproc_ctl;

  localparam int EDEPTH = 4;
  localparam logic [3:0] OP_ERET = 4'b0100;
  localparam logic [3:0] OP_MFC  = 4'b0110;
  localparam logic [3:0] OP_MTC  = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs_data;
  logic [4:0]  rs_num, rd_num;
  logic [8:0]  opcode;
  logic        ci;
  logic [19:0] cec;
  logic [3:0]  itype;
  logic        exc;
  logic [27:0] vpc;
  logic [31:0] va0, va1;
  logic [31:0] result;
  logic        rd_we, branch, user, paging, ie, irq, dfault;
  logic [27:0] baddr;
  logic [19:0] pdbase;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic        m_ie, m_pg, m_df, m_user, m_pend, m_dfp;
  logic [31:0] m_ptb, m_eha, m_epc, m_cmp, mcyc;
  logic [8:0]  m_ec [4];
  logic [31:0] m_va [2];
  logic [31:0] m_scr [8];
  logic [31:0] m_stack [$];

  mcpu_core_coproc_ctl #(.NUM_SCRATCH(8), .NUM_LANES(4), .ESTACK_DEPTH(EDEPTH), .CYCLE_W(32)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst(rst),
    .d2pc_in_rs_data0(rs_data), .d2pc_in_rs_num0(rs_num), .d2pc_in_rd_num0(rd_num),
    .d2pc_in_execute_opcode0(opcode), .coproc_instruction(ci), .combined_ec(cec),
    .int_type(itype), .exception(exc), .d2pc_in_virtpc(vpc),
    .mem_vaddr0(va0), .mem_vaddr1(va1),
    .coproc_reg_result(result), .coproc_rd_we(rd_we), .coproc_branch(branch),
    .coproc_branchaddr(baddr), .user_mode(user), .paging_on(paging),
    .interrupts_enabled(ie), .pagedir_base(pdbase), .timer_irq(irq), .double_fault(dfault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx[4]) return m_scr[idx[2:0]];
    case (idx[3:0])
      4'd0:  return {29'b0, m_df, m_pg, m_ie};
      4'd1:  return m_ptb;
      4'd2:  return m_eha;
      4'd3:  return m_epc;
      4'd4, 4'd5, 4'd6, 4'd7: return {23'b0, m_ec[idx[1:0]]};
      4'd8:  return m_va[0];
      4'd9:  return m_va[1];
      4'd10: return mcyc;
      4'd11: return m_cmp;
      4'd13: return 32'(m_stack.size());
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ie = 0; m_pg = 0; m_df = 0; m_user = 0; m_pend = 0; m_dfp = 0;
    m_ptb = 0; m_eha = 0; m_epc = 0; m_cmp = 0; mcyc = 0;
    for (int l = 0; l < 4; l++) m_ec[l] = 0;
    m_va[0] = 0; m_va[1] = 0;
    for (int s = 0; s < 8; s++) m_scr[s] = 0;
    m_stack.delete();
  endtask

  task automatic set_idle();
    ci = 0; opcode = 0; exc = 0; rs_num = 0; rd_num = 0; rs_data = 0;
    cec = 0; itype = 0; vpc = 0; va0 = 0; va1 = 0;
  endtask

  // Advance the model by the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic [3:0] op;
    logic do_eret, do_mtc, n_pend;
    op = opcode[8:5];
    do_eret = ci && op == OP_ERET;
    do_mtc  = ci && op == OP_MTC;
    n_pend  = m_pend || (mcyc == m_cmp && m_cmp != 0);
    m_dfp   = 1'b0;
    if (exc) begin
      if (m_stack.size() < EDEPTH) m_stack.push_back(m_epc);
      else begin m_df = 1; m_dfp = 1; end
      m_epc = {vpc, 2'b00, m_ie, ~m_user};
      m_ie = 0; m_user = 0;
      m_ec[0] = {itype, cec[4:0]};
      for (int l = 1; l < 4; l++) m_ec[l] = {4'b0, cec[5*l +: 5]};
      m_va[0] = va0; m_va[1] = va1;
    end else if (do_eret) begin
      m_user = ~m_epc[0];
      m_ie = m_epc[1];
      if (m_stack.size() > 0) m_epc = m_stack.pop_back();
    end else if (do_mtc) begin
      if (rd_num[4]) m_scr[rd_num[2:0]] = rs_data;
      else case (rd_num[3:0])
        4'd0: begin m_ie = rs_data[0]; m_pg = rs_data[1]; if (!rs_data[2]) m_df = 0; end
        4'd1: m_ptb = rs_data;
        4'd2: m_eha = rs_data;
        4'd3: m_epc = rs_data;
        4'd4: m_ec[0] = rs_data[8:0];
        4'd5, 4'd6, 4'd7: m_ec[rd_num[1:0]] = {4'b0, rs_data[4:0]};
        4'd8: m_va[0] = rs_data;
        4'd9: m_va[1] = rs_data;
        4'd11: begin m_cmp = rs_data; n_pend = 0; end
        default: ;
      endcase
    end
    m_pend = n_pend;
    mcyc = mcyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic mtc(input logic [4:0] idx, input logic [31:0] d);
    ci = 1; opcode = {OP_MTC, 5'h0}; rd_num = idx; rs_data = d;
    tick();
    set_idle();
  endtask

  task automatic eret();
    ci = 1; opcode = {OP_ERET, 5'h0};
    tick();
    set_idle();
  endtask

  task automatic take_exc(input logic [27:0] pc);
    exc = 1; vpc = pc; cec = 20'($urandom); itype = 4'($urandom);
    va0 = $urandom; va1 = $urandom;
    tick();
    set_idle();
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [4:0] idx [3];
    idx[0] = 5'd0; idx[1] = 5'd3; idx[2] = 5'd10;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      rs_num = idx[i]; #1;
      n_checks++;
      if (result !== 32'h0) begin n_errors++; $display("FAIL reset_read[%0d]: got %h want 0", idx[i], result); end
    end
    n_checks++;
    if ({user, ie, paging, dfault, irq, branch} !== 6'b0) begin
      n_errors++; $display("FAIL reset_outputs: got %b want 000000", {user, ie, paging, dfault, irq, branch});
    end
    repeat (5) tick();
    rs_num = 5'd10; #1;
    n_checks++;
    if (result !== 32'd5) begin n_errors++; $display("FAIL cycle_count: got %0d want 5", result); end
    ci = 1; opcode = {OP_MFC, 5'h1f}; #1;
    n_checks++;
    if (rd_we !== 1'b1) begin n_errors++; $display("FAIL mfc_rd_we: got %b want 1", rd_we); end
    set_idle();
  endtask

  task automatic test_exception();
    logic [19:0] ec_s; logic [3:0] it_s; logic [31:0] v0_s;
    apply_reset();
    mtc(5'd2, 32'h1000);
    mtc(5'd3, 32'h2);
    eret();
    n_checks++;
    if ({user, ie} !== 2'b11) begin n_errors++; $display("FAIL eret_to_user: got %b want 11", {user, ie}); end
    ec_s = 20'($urandom); it_s = 4'($urandom); v0_s = $urandom;
    exc = 1; vpc = 28'h123; cec = ec_s; itype = it_s; va0 = v0_s; va1 = ~v0_s;
    #1;
    n_checks++;
    if ({branch, baddr} !== {1'b1, 28'h100}) begin
      n_errors++; $display("FAIL exc_branch: got %b/%h want 1/0000100", branch, baddr);
    end
    tick();
    set_idle();
    rs_num = 5'd3; #1;
    n_checks++;
    if (result !== 32'h1232) begin n_errors++; $display("FAIL exc_epc: got %h want 00001232", result); end
    n_checks++;
    if ({user, ie} !== 2'b00) begin n_errors++; $display("FAIL exc_mode: got %b want 00", {user, ie}); end
    rs_num = 5'd4; #1;
    n_checks++;
    if (result !== {23'b0, it_s, ec_s[4:0]}) begin
      n_errors++; $display("FAIL exc_ec0: got %h want %h", result, {23'b0, it_s, ec_s[4:0]});
    end
    rs_num = 5'd7; #1;
    n_checks++;
    if (result !== {27'b0, ec_s[19:15]}) begin
      n_errors++; $display("FAIL exc_ec3: got %h want %h", result, {27'b0, ec_s[19:15]});
    end
    rs_num = 5'd8; #1;
    n_checks++;
    if (result !== v0_s) begin n_errors++; $display("FAIL exc_vaddr0: got %h want %h", result, v0_s); end
    rs_num = 5'd13; #1;
    n_checks++;
    if (result !== 32'd1) begin n_errors++; $display("FAIL exc_depth: got %0d want 1", result); end
  endtask

  task automatic test_nested();
    logic [27:0] pcs [5];
    logic [31:0] want;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      pcs[k] = 28'($urandom);
      take_exc(pcs[k]);
      rs_num = 5'd13; #1;
      n_checks++;
      if (result !== ((k < 4) ? k + 1 : 4)) begin
        n_errors++; $display("FAIL nest_depth[%0d]: got %0d want %0d", k, result, (k < 4) ? k + 1 : 4);
      end
      n_checks++;
      if (dfault !== (k == 4)) begin n_errors++; $display("FAIL nest_df_pulse[%0d]: got %b want %b", k, dfault, k == 4); end
    end
    rs_num = 5'd0; #1;
    n_checks++;
    if (result[2] !== 1'b1) begin n_errors++; $display("FAIL df_sticky: got %b want 1", result[2]); end
    tick();
    n_checks++;
    if (dfault !== 1'b0) begin n_errors++; $display("FAIL df_one_cycle: got %b want 0", dfault); end
    for (int j = 0; j < 5; j++) begin
      ci = 1; opcode = {OP_ERET, 5'h0}; #1;
      n_checks++;
      if (baddr !== m_epc[31:4]) begin n_errors++; $display("FAIL eret_target[%0d]: got %h want %h", j, baddr, m_epc[31:4]); end
      tick();
      set_idle();
      want = (j < 3) ? {pcs[2-j], 4'b0001} : 32'h0;
      rs_num = 5'd3; #1;
      n_checks++;
      if (result !== want) begin n_errors++; $display("FAIL eret_lifo[%0d]: got %h want %h", j, result, want); end
    end
    mtc(5'd0, 32'h0);
    rs_num = 5'd0; #1;
    n_checks++;
    if (result !== 32'h0) begin n_errors++; $display("FAIL df_clear: got %h want 0", result); end
  endtask

  task automatic test_timer();
    logic [31:0] x;
    apply_reset();
    mtc(5'd0, 32'h1);
    mtc(5'd11, 32'd20);
    while (mcyc < 26) begin
      n_checks++;
      if (irq !== (mcyc >= 21)) begin n_errors++; $display("FAIL timer_match@%0d: got %b want %b", mcyc, irq, mcyc >= 21); end
      tick();
    end
    mtc(5'd0, 32'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL timer_ie_gate: got %b want 0", irq); end
    mtc(5'd0, 32'h1);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL timer_sticky: got %b want 1", irq); end
    mtc(5'd11, 32'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL timer_clear: got %b want 0", irq); end
    x = mcyc + 3;
    mtc(5'd11, x);
    while (mcyc != x) tick();
    mtc(5'd11, 32'h0);
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL timer_write_wins: got %b want 0", irq); end
  endtask

  task automatic test_priority();
    logic [31:0] a, e_before;
    a = $urandom;
    mtc(5'h15, a);
    mtc(5'd2, 32'hABCD_0000);
    e_before = m_eha;
    exc = 1; vpc = 28'($urandom); ci = 1; opcode = {OP_MTC, 5'h0}; rd_num = 5'h15; rs_data = ~a;
    #1;
    n_checks++;
    if (baddr !== e_before[31:4]) begin n_errors++; $display("FAIL prio_target: got %h want %h", baddr, e_before[31:4]); end
    tick();
    rd_num = 5'd2; exc = 1; rs_data = 32'h5555_5555;
    tick();
    set_idle();
    rs_num = 5'h15; #1;
    n_checks++;
    if (result !== a) begin n_errors++; $display("FAIL prio_mtc_dropped: got %h want %h", result, a); end
    rs_num = 5'd2; #1;
    n_checks++;
    if (result !== 32'hABCD_0000) begin n_errors++; $display("FAIL prio_eha_kept: got %h want abcd0000", result); end
    mtc(5'd3, 32'h2);
    exc = 1; vpc = 28'h777; ci = 1; opcode = {OP_ERET, 5'h0};
    tick();
    set_idle();
    rs_num = 5'd3; #1;
    n_checks++;
    if ({user, result} !== {1'b0, m_epc}) begin
      n_errors++; $display("FAIL prio_exc_over_eret: got %b/%h want 0/%h", user, result, m_epc);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      mtc(5'h10 | 5'(i), vals[i]);
    end
    for (int i = 0; i < 8; i++) begin
      rs_num = 5'h10 | 5'(i); #1;
      n_checks++;
      if (result !== vals[i]) begin n_errors++; $display("FAIL scratch[%0d]: got %h want %h", i, result, vals[i]); end
    end
    mtc(5'h17, 32'hDEAD_BEEF);
    rs_num = 5'h17; #1;
    n_checks++;
    if (result !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL scratch7: got %h want deadbeef", result); end
    mtc(5'h0E, $urandom);
    rs_num = 5'h0E; #1;
    n_checks++;
    if (result !== 32'h0) begin n_errors++; $display("FAIL unmapped_0e: got %h want 0", result); end
    mtc(5'd10, 32'hFFFF_0000);
    rs_num = 5'd10; #1;
    n_checks++;
    if (result !== mcyc) begin n_errors++; $display("FAIL cycle_ro: got %h want %h", result, mcyc); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = OP_ERET;
        2, 3, 4: op = OP_MTC;
        5, 6:    op = OP_MFC;
        default: op = 4'($urandom);
      endcase
      ci = ($urandom_range(0, 7) != 0);
      opcode = {op, 5'($urandom)};
      exc = ($urandom_range(0, 11) == 0);
      rd_num = 5'($urandom); rs_num = 5'($urandom);
      rs_data = $urandom;
      if (rd_num[3:0] == 4'd11 && $urandom_range(0, 1) == 1) rs_data = mcyc + $urandom_range(1, 6);
      vpc = 28'($urandom); cec = 20'($urandom); itype = 4'($urandom); va0 = $urandom; va1 = $urandom;
      #1;
      n_checks++;
      if (result !== m_read(rs_num)) begin
        n_errors++; $display("FAIL rand_read[%0d] rs=%h: got %h want %h", n, rs_num, result, m_read(rs_num));
      end
      n_checks++;
      if ({rd_we, branch, user, ie, paging, irq, dfault} !==
          {ci && op == OP_MFC, exc || (ci && op == OP_ERET), m_user, m_ie, m_pg, m_pend && m_ie, m_dfp}) begin
        n_errors++;
        $display("FAIL rand_status[%0d]: got %b want %b", n, {rd_we, branch, user, ie, paging, irq, dfault},
                 {ci && op == OP_MFC, exc || (ci && op == OP_ERET), m_user, m_ie, m_pg, m_pend && m_ie, m_dfp});
      end
      n_checks++;
      if ({pdbase, (branch ? baddr : 28'h0)} !== {m_ptb[31:12], (exc ? m_eha[31:4] : (ci && op == OP_ERET) ? m_epc[31:4] : 28'h0)}) begin
        n_errors++; $display("FAIL rand_addr[%0d]: got %h/%h want %h", n, pdbase, baddr, m_ptb[31:12]);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    mtc(5'h13, 32'h1234_5678);
    mtc(5'd3, 32'h2);
    eret();
    ci = 1; opcode = {OP_MTC, 5'h0}; rd_num = 5'h13; rs_data = 32'h1;
    #2;
    rst = 1;
    #1;
    rs_num = 5'd10; #1;
    n_checks++;
    if ({user, result} !== 33'h0) begin n_errors++; $display("FAIL midreset_cycle: got %b/%h want 0/0", user, result); end
    rs_num = 5'h13; #1;
    n_checks++;
    if (result !== 32'h0) begin n_errors++; $display("FAIL midreset_scratch: got %h want 0", result); end
    set_idle();
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    tick(); tick();
    rs_num = 5'd10; #1;
    n_checks++;
    if (result !== 32'd2) begin n_errors++; $display("FAIL midreset_restart: got %0d want 2", result); end
  endtask

  initial begin
    rst = 1;
    set_idle();
    model_reset();
    test_reset();
    test_exception();
    test_nested();
    test_timer();
    test_priority();
    test_scratch();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
